serial_word_capture: RTL and testbench

- Downstream consumer of the positive-edge load-enable D flip-flop stage.
- Samples that stage's registered serial output whenever the shared load enable is high.
- Assembles WIDTH consecutive enabled bits into a parallel word and presents it with a valid/acknowledge handshake to the next stage.
- Uses the same clock and the same enable as the flip-flop stage, so one enable pulse moves one bit through both.

---
 rtl/serial_word_capture_pkg.sv | 15 +
 rtl/serial_word_capture_if.sv | 27 ++
 rtl/serial_word_capture_shift_reg_en.sv | 35 +++
 rtl/serial_word_capture.sv | 115 +++++++++++
 tb/tb_serial_word_capture.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_capture_pkg.sv
// rtl/serial_word_capture_pkg.sv - shared FSM encoding and counter sizing for serial_word_capture
package serial_word_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_capture_if.sv
// rtl/serial_word_capture_if.sv - serial-in / word-out handshake bundle for serial_word_capture
interface serial_word_capture_if #(
    parameter int WIDTH = 8
);
    localparam int CW = serial_word_capture_pkg::cnt_width(WIDTH);

    logic             d_in;
    logic             en_in;
    logic             start_in;
    logic             rd_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             busy_out;
    logic [CW-1:0]    bit_cnt_out;
    logic             overrun_out;

    modport slave (
        input  d_in, en_in, start_in, rd_in,
        output data_out, valid_out, busy_out, bit_cnt_out, overrun_out
    );

    modport master (
        output d_in, en_in, start_in, rd_in,
        input  data_out, valid_out, busy_out, bit_cnt_out, overrun_out
    );

endinterface

// File: rtl/serial_word_capture_shift_reg_en.sv
// rtl/serial_word_capture_shift_reg_en.sv - load-enable shift register exposing its next value
module shift_reg_en #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_d,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // After WIDTH shifts the first bit sits at the MSB (left shift) or LSB (right shift).
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_next = {r_q[WIDTH-2:0], i_d};
        end else begin : g_lsb
            assign w_next = {i_d, r_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_next = w_next;

endmodule

// File: rtl/serial_word_capture.sv
// rtl/serial_word_capture.sv - assembles enabled serial bits into a word with valid/ack handshake
module serial_word_capture
    import serial_word_capture_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_in,
    serial_word_capture_if.slave  sif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic             r_overrun;
    logic             w_overrun_nxt;
    logic             r_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_word_nxt;
    logic             w_shift_en;
    logic             w_load;
    logic             w_last_bit;

    shift_reg_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .rst    (reset_in),
        .i_en   (w_shift_en),
        .i_d    (sif.d_in),
        .o_next (w_word_nxt)
    );

    assign w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next_state  = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_overrun_nxt = r_overrun;
        w_shift_en    = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sif.start_in) begin
                    w_next_state  = ST_SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_overrun_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sif.en_in) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
                        w_load        = 1'b1;
                        w_bit_cnt_nxt = CW'(WIDTH);
                        w_next_state  = ST_FULL;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    end
                end
            end
            ST_FULL: begin
                // An acknowledge on the same edge swallows the stray bit silently.
                if (sif.rd_in) begin
                    w_bit_cnt_nxt = '0;
                    if (sif.start_in) begin
                        w_next_state  = ST_SHIFT;
                        w_overrun_nxt = 1'b0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (sif.en_in) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_overrun <= w_overrun_nxt;
            r_valid   <= (w_next_state == ST_FULL);
            r_busy    <= (w_next_state == ST_SHIFT);
            if (w_load) begin
                r_data <= w_word_nxt;
            end
        end
    end

    assign sif.data_out    = r_data;
    assign sif.valid_out   = r_valid;
    assign sif.busy_out    = r_busy;
    assign sif.bit_cnt_out = r_bit_cnt;
    assign sif.overrun_out = r_overrun;

endmodule

// File: tb/tb_serial_word_capture.sv
// tb/tb_serial_word_capture.sv - self-checking bench for serial_word_capture (both bit orders)
module tb_serial_word_capture;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d   = 1'b0;
    logic en  = 1'b0;
    logic st  = 1'b0;
    logic rd  = 1'b0;
    bit   cmp_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_capture_if #(.WIDTH(W)) if_m ();
    serial_word_capture_if #(.WIDTH(W)) if_l ();

    assign if_m.d_in     = d;
    assign if_m.en_in    = en;
    assign if_m.start_in = st;
    assign if_m.rd_in    = rd;
    assign if_l.d_in     = d;
    assign if_l.en_in    = en;
    assign if_l.start_in = st;
    assign if_l.rd_in    = rd;

    serial_word_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .reset_in (rst),
        .sif      (if_m.slave)
    );

    serial_word_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk      (clk),
        .reset_in (rst),
        .sif      (if_l.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: phase 0=waiting for start, 1=collecting, 2=word held.
    int             m_phase;
    int             m_cnt;
    bit             m_ov;
    logic [W-1:0]   m_word_m;
    logic [W-1:0]   m_word_l;
    bit             m_bits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  = 0;
            m_cnt    = 0;
            m_ov     = 1'b0;
            m_word_m = '0;
            m_word_l = '0;
            m_bits.delete();
        end else begin
            if (m_phase == 0) begin
                if (st) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_ov    = 1'b0;
                    m_bits.delete();
                end
            end else if (m_phase == 1) begin
                if (en) begin
                    m_bits.push_back(d);
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_word_m = '0;
                        m_word_l = '0;
                        for (int i = 0; i < W; i++) begin
                            m_word_m = m_word_m | (W'(m_bits[i]) << (W - 1 - i));
                            m_word_l = m_word_l | (W'(m_bits[i]) << i);
                        end
                        m_phase = 2;
                    end
                end
            end else begin
                if (rd) begin
                    m_cnt = 0;
                    m_bits.delete();
                    if (st) begin
                        m_phase = 1;
                        m_ov    = 1'b0;
                    end else begin
                        m_phase = 0;
                    end
                end else if (en) begin
                    m_ov = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m.valid",   if_m.valid_out,   32'(m_phase == 2));
            check("m.busy",    if_m.busy_out,    32'(m_phase == 1));
            check("m.cnt",     if_m.bit_cnt_out, 32'(m_cnt));
            check("m.overrun", if_m.overrun_out, 32'(m_ov));
            check("m.data",    if_m.data_out,    32'(m_word_m));
            check("l.valid",   if_l.valid_out,   32'(m_phase == 2));
            check("l.busy",    if_l.busy_out,    32'(m_phase == 1));
            check("l.cnt",     if_l.bit_cnt_out, 32'(m_cnt));
            check("l.overrun", if_l.overrun_out, 32'(m_ov));
            check("l.data",    if_l.data_out,    32'(m_word_l));
        end
    end

    task automatic cyc(input logic id, input logic ien, input logic ist, input logic ird);
        @(negedge clk);
        #1;
        d  = id;
        en = ien;
        st = ist;
        rd = ird;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic b,
                              input int c, input logic o);
        check({tag, ".valid"},   if_m.valid_out,   32'(v));
        check({tag, ".busy"},    if_m.busy_out,    32'(b));
        check({tag, ".cnt"},     if_m.bit_cnt_out, 32'(c));
        check({tag, ".overrun"}, if_m.overrun_out, 32'(o));
    endtask

    logic [7:0] pat;

    initial begin
        pat = 8'b1011_0010;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 0, 1'b0);
        check("reset.data", if_m.data_out, 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Contiguous stream, both bit orders
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) cyc(pat[i], 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("msb.data", if_m.data_out, 32'hB2);
        check("lsb.data", if_l.data_out, 32'h4D);
        check_outs("full1", 1'b1, 1'b0, 8, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("ack", 1'b0, 1'b0, 0, 1'b0);
        check("ack.data_kept", if_m.data_out, 32'hB2);

        // Enable every other cycle
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            cyc(pat[i], 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7) check("gap.cnt1", if_m.bit_cnt_out, 32'd1);
        end
        check("gap.data", if_m.data_out, 32'hB2);
        check_outs("gap.full", 1'b1, 1'b0, 8, 1'b0);

        // Overrun, then acknowledge plus restart on one edge
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("ovr", 1'b1, 1'b0, 8, 1'b1);
        check("ovr.data", if_m.data_out, 32'hB2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("b2b", 1'b0, 1'b1, 0, 1'b0);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("part.cnt", if_m.bit_cnt_out, 32'd5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async", 1'b0, 1'b0, 0, 1'b0);
        check("async.data", if_m.data_out, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("ff.msb", if_m.data_out, 32'hFF);
        check("ff.lsb", if_l.data_out, 32'hFF);
        check_outs("ff", 1'b1, 1'b0, 8, 1'b0);

        // Idle: enable and data toggle without start
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'(i % 2), 1'b0, 1'b0);
            check_outs("idle", 1'b0, 1'b0, 0, 1'b0);
        end
        check("idle.data", if_m.data_out, 32'hFF);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            d   = 1'($urandom_range(0, 1));
            en  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 2) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
